// File: rtl/kbd_pkg.sv
// Shared scancode constants, decoder state encoding and the queued key-event type
// for the keyboard event router.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } kbd_dec_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } kbd_evt_t;

endpackage

// File: rtl/kbd_event_router_if.sv
// Byte stream from the PS/2 receiver plus the routed key-event handshake to the
// menu and game consumers.
interface kbd_event_router_if;
  logic [7:0] ps_data;
  logic       ready;
  logic       is_start;
  logic       menu_ack;
  logic       game_ack;
  logic       menu_valid;
  logic       game_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       overflow;
  logic       held;

  modport master (
    output ps_data, ready, is_start, menu_ack, game_ack,
    input  menu_valid, game_valid, key_code, key_ext, overflow, held
  );

  modport slave (
    input  ps_data, ready, is_start, menu_ack, game_ack,
    output menu_valid, game_valid, key_code, key_ext, overflow, held
  );
endinterface

// File: rtl/kbd_evt_fifo.sv
// Synchronous key-event FIFO (pointer + count) with a flush that empties it in one
// cycle. Push and pop may coincide at any occupancy, including full.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     flush_i,
  input  kbd_evt_t evt_i,
  output kbd_evt_t head_o,
  output logic     empty_o,
  output logic     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  kbd_evt_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign rd_en   = pop_i & ~empty_o & ~flush_i;
  assign wr_en   = push_i & ~flush_i & (~full_o | rd_en);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= evt_i;
  end

endmodule

// File: rtl/kbd_event_router.sv
// Decodes PS/2 make/break/extended scancodes into key-press events, queues them and
// routes the head to the menu or the game. Optional KBD_TYPEMATIC_FILTER_EN drops auto-repeat makes.
module kbd_event_router
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  kbd_event_router_if.slave bus
);

  kbd_dec_state_t state_q, state_d;
  logic           ready_q, is_start_q;
  logic [7:0]     last_make_q, last_make_d;
  logic           held_q, held_d, overflow_q, overflow_d;
  logic           byte_stb, flush, make_stb, make_ext, brk_stb, push_req, pop;
  logic           menu_vld, game_vld, fifo_empty, fifo_full;
  kbd_evt_t       push_evt, head_evt;

  assign byte_stb = bus.ready & ~ready_q;
  assign flush    = bus.is_start ^ is_start_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (byte_stb) begin
      case (state_q)
        IDLE: begin
          if (bus.ps_data == SC_EXT)        state_d = EXT;
          else if (bus.ps_data == SC_BREAK) state_d = BRK;
        end
        EXT:     state_d = (bus.ps_data == SC_BREAK) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    make_stb = 1'b0;
    make_ext = 1'b0;
    brk_stb  = 1'b0;
    case (state_q)
      IDLE: make_stb = byte_stb & (bus.ps_data != SC_EXT) & (bus.ps_data != SC_BREAK);
      EXT: begin
        make_stb = byte_stb & (bus.ps_data != SC_BREAK);
        make_ext = 1'b1;
      end
      BRK:     brk_stb = byte_stb;
      default: ;
    endcase
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic is_repeat;
  assign is_repeat = ~make_ext & held_q & (bus.ps_data == last_make_q);
  assign push_req  = make_stb & ~is_repeat;
`else
  assign push_req  = make_stb;
`endif

  assign push_evt = '{ext: make_ext, code: bus.ps_data};
  assign pop      = (menu_vld & bus.menu_ack) | (game_vld & bus.game_ack);

  always_comb begin
    last_make_d = last_make_q;
    held_d      = held_q;
    if (make_stb & ~make_ext) begin
      last_make_d = bus.ps_data;
      held_d      = 1'b1;
    end else if (brk_stb && (bus.ps_data == last_make_q)) begin
      held_d = 1'b0;
    end
    overflow_d = overflow_q | (push_req & ~flush & fifo_full & ~pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      is_start_q  <= 1'b0;
      last_make_q <= '0;
      held_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ready_q     <= bus.ready;
      is_start_q  <= bus.is_start;
      last_make_q <= last_make_d;
      held_q      <= held_d;
      overflow_q  <= overflow_d;
    end
  end

  kbd_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .flush_i (flush),
    .evt_i   (push_evt),
    .head_o  (head_evt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // The new owner sees nothing while its stale queue is being flushed.
  assign menu_vld = ~fifo_empty & ~flush & ~bus.is_start;
  assign game_vld = ~fifo_empty & ~flush &  bus.is_start;

  assign bus.menu_valid = menu_vld;
  assign bus.game_valid = game_vld;
  assign bus.key_code   = fifo_empty ? 8'h00 : head_evt.code;
  assign bus.key_ext    = ~fifo_empty & head_evt.ext;
  assign bus.overflow   = overflow_q;
  assign bus.held       = held_q;

endmodule

// File: tb/tb_kbd_event_router.sv
// Self-checking bench for kbd_event_router: directed scenarios plus randomized
// byte/ack/owner traffic compared against a queue-based reference model.
module tb_kbd_event_router;
  import kbd_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  kbd_event_router_if bus ();

  kbd_event_router #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: events as {ext, code}, prefix bytes tracked as pending flags.
  logic [8:0] q[$];
  logic       m_over, m_held, m_ext, m_brk, m_ready_q, m_is_start_q;
  logic [7:0] m_last;
  logic [7:0] popped[$];

  task automatic model_reset();
    q.delete();
    m_over = 0; m_held = 0; m_ext = 0; m_brk = 0;
    m_ready_q = 0; m_is_start_q = 0; m_last = 8'h00;
  endtask

  task automatic model_edge();
    logic fl, pop, strobe, make, ext, drop;
    logic [7:0] b;
    fl     = (bus.is_start != m_is_start_q);
    pop    = (q.size() > 0) && !fl && (bus.is_start ? bus.game_ack : bus.menu_ack);
    strobe = bus.ready && !m_ready_q;
    b      = bus.ps_data;
    make   = 0;
    ext    = 0;
    drop   = 0;
    if (strobe) begin
      if (m_brk) begin
        if (!m_ext && b == m_last) m_held = 0;
        m_brk = 0;
        m_ext = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b == 8'hE0 && !m_ext) begin
        m_ext = 1;
      end else begin
        make  = 1;
        ext   = m_ext;
        m_ext = 0;
      end
    end
    if (fl) q.delete();
    else if (pop) void'(q.pop_front());
    if (make) begin
`ifdef KBD_TYPEMATIC_FILTER_EN
      if (!ext && m_held && b == m_last) drop = 1;
`endif
      if (!ext) begin
        m_last = b;
        m_held = 1;
      end
      if (!drop && !fl) begin
        if (q.size() < DEPTH) q.push_back({ext, b});
        else m_over = 1;
      end
    end
    m_ready_q    = bus.ready;
    m_is_start_q = bus.is_start;
  endtask

  function automatic logic [12:0] exp_vec();
    logic e, fl;
    e  = (q.size() == 0);
    fl = (bus.is_start != m_is_start_q);
    return {!e && !bus.is_start && !fl, !e && bus.is_start && !fl,
            e ? 1'b0 : q[0][8], e ? 8'h00 : q[0][7:0], m_over, m_held};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.menu_valid, bus.game_valid, bus.key_ext, bus.key_code, bus.overflow, bus.held};
  endfunction

  function automatic logic [12:0] mk(input logic mv, input logic gv, input logic ext,
                                     input logic [7:0] code, input logic ov, input logic hd);
    return {mv, gv, ext, code, ov, hd};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.ps_data = b;
    bus.ready   = 1;
    tick();
    bus.ready   = 0;
    tick();
  endtask

  task automatic drain();
    popped.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (bus.menu_valid || bus.game_valid) begin
        popped.push_back(bus.key_code);
        if (bus.game_valid) bus.game_ack = 1;
        else bus.menu_ack = 1;
      end
      tick();
      bus.menu_ack = 0;
      bus.game_ack = 0;
    end
  endtask

  task automatic do_reset();
    bus.ready = 0; bus.menu_ack = 0; bus.game_ack = 0; bus.is_start = 0; bus.ps_data = 8'h00;
    reset = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h00, 0, 0)) $display("FAIL reset_state: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h00, 0, 0));
    else n_pass++;
  endtask

  task automatic test_menu_break();
    send(8'h1C);
    n_checks++;
    if (dut_vec() !== mk(1, 0, 0, 8'h1C, 0, 1)) $display("FAIL menu_make: got %h expected %h", dut_vec(), mk(1, 0, 0, 8'h1C, 0, 1));
    else n_pass++;
    send(SC_BREAK);
    send(8'h1C);
    n_checks++;
    if (dut_vec() !== mk(1, 0, 0, 8'h1C, 0, 0)) $display("FAIL menu_break: got %h expected %h", dut_vec(), mk(1, 0, 0, 8'h1C, 0, 0));
    else n_pass++;
    bus.menu_ack = 1;
    tick();
    bus.menu_ack = 0;
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h00, 0, 0)) $display("FAIL menu_pop: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h00, 0, 0));
    else n_pass++;
  endtask

  task automatic test_game_ext();
    bus.is_start = 1;
    tick();
    tick();
    send(SC_EXT);
    send(8'h75);
    send(SC_EXT);
    send(SC_BREAK);
    send(8'h75);
    n_checks++;
    if (dut_vec() !== mk(0, 1, 1, 8'h75, 0, 0)) $display("FAIL game_ext: got %h expected %h", dut_vec(), mk(0, 1, 1, 8'h75, 0, 0));
    else n_pass++;
    bus.menu_ack = 1;
    tick();
    bus.menu_ack = 0;
    n_checks++;
    if (dut_vec() !== mk(0, 1, 1, 8'h75, 0, 0)) $display("FAIL game_wrong_ack: got %h expected %h", dut_vec(), mk(0, 1, 1, 8'h75, 0, 0));
    else n_pass++;
    bus.game_ack = 1;
    tick();
    bus.game_ack = 0;
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h00, 0, 0)) $display("FAIL game_pop: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h00, 0, 0));
    else n_pass++;
  endtask

  task automatic test_typematic();
    int exp_n;
`ifdef KBD_TYPEMATIC_FILTER_EN
    exp_n = 1;
`else
    exp_n = 3;
`endif
    bus.is_start = 0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) send(8'h1C);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL typematic_head: got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
    drain();
    n_checks++;
    if (popped.size() !== exp_n) $display("FAIL typematic_count: got %0d expected %0d", popped.size(), exp_n);
    else n_pass++;
    foreach (popped[i]) begin
      n_checks++;
      if (popped[i] !== 8'h1C) $display("FAIL typematic_code: got %h expected 1c", popped[i]);
      else n_pass++;
    end
    send(SC_BREAK);
    send(8'h1C);
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h00, 0, 0)) $display("FAIL typematic_release: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h00, 0, 0));
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    for (int i = 0; i < 5; i++) send(codes[i]);
    n_checks++;
    if (dut_vec() !== mk(1, 0, 0, 8'h15, 1, 1)) $display("FAIL overflow_flag: got %h expected %h", dut_vec(), mk(1, 0, 0, 8'h15, 1, 1));
    else n_pass++;
    drain();
    n_checks++;
    if (popped.size() !== DEPTH) $display("FAIL overflow_count: got %0d expected %0d", popped.size(), DEPTH);
    else n_pass++;
    foreach (popped[i]) begin
      n_checks++;
      if (popped[i] !== codes[i]) $display("FAIL overflow_order: got %h expected %h", popped[i], codes[i]);
      else n_pass++;
    end
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h00, 1, 1)) $display("FAIL overflow_sticky: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h00, 1, 1));
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    send(8'h1C);
    send(8'h32);
    bus.is_start = 1;
    #1;
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h1C, 0, 1)) $display("FAIL flush_cycle: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h1C, 0, 1));
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h00, 0, 1)) $display("FAIL flush_empty: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h00, 0, 1));
    else n_pass++;
    send(8'h16);
    n_checks++;
    if (dut_vec() !== mk(0, 1, 0, 8'h16, 0, 1)) $display("FAIL flush_new_owner: got %h expected %h", dut_vec(), mk(0, 1, 0, 8'h16, 0, 1));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_codes [4];
    exp_codes = '{8'h1B, 8'h23, 8'h2B, 8'h34};
    do_reset();
    send(8'h1C);
    send(8'h1B);
    send(8'h23);
    send(8'h2B);
    bus.ps_data  = 8'h34;
    bus.ready    = 1;
    bus.menu_ack = 1;
    tick();
    bus.ready    = 0;
    bus.menu_ack = 0;
    n_checks++;
    if (dut_vec() !== mk(1, 0, 0, 8'h1B, 0, 1)) $display("FAIL full_pushpop: got %h expected %h", dut_vec(), mk(1, 0, 0, 8'h1B, 0, 1));
    else n_pass++;
    tick();
    drain();
    n_checks++;
    if (popped.size() !== DEPTH) $display("FAIL full_pushpop_count: got %0d expected %0d", popped.size(), DEPTH);
    else n_pass++;
    foreach (popped[i]) begin
      n_checks++;
      if (popped[i] !== exp_codes[i]) $display("FAIL full_pushpop_order: got %h expected %h", popped[i], exp_codes[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    send(8'h1C);
    send(SC_BREAK);
    reset = 1;
    #1;
    n_checks++;
    if (dut_vec() !== mk(0, 0, 0, 8'h00, 0, 0)) $display("FAIL reset_mid: got %h expected %h", dut_vec(), mk(0, 0, 0, 8'h00, 0, 0));
    else n_pass++;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
    send(8'h29);
    n_checks++;
    if (dut_vec() !== mk(1, 0, 0, 8'h29, 0, 1)) $display("FAIL reset_mid_next: got %h expected %h", dut_vec(), mk(1, 0, 0, 8'h29, 0, 1));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    pool = '{SC_EXT, SC_BREAK, 8'h1C, 8'h1B, 8'h23, 8'h29, SC_ENTER, SC_BKSP};
    for (int i = 0; i < 600; i++) begin
      if (bus.ready) bus.ready = 0;
      else if ($urandom_range(0, 1) == 1) begin
        bus.ready   = 1;
        bus.ps_data = pool[$urandom_range(0, 7)];
      end
      bus.menu_ack = ($urandom_range(0, 3) == 0);
      bus.game_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) bus.is_start = ~bus.is_start;
      #1;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    bus.ready    = 0;
    bus.menu_ack = 0;
    bus.game_ack = 0;
  endtask

  initial begin
    reset = 1;
    bus.ps_data = 8'h00; bus.ready = 0; bus.is_start = 0; bus.menu_ack = 0; bus.game_ack = 0;
    test_reset();
    test_menu_break();
    test_game_ext();
    test_typematic();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kbd_event_router.md
# kbd_event_router

Keyboard event controller between the PS/2 receiver and its two consumers: the menu/panel controller and the game engine. Decodes the raw scancode byte stream (make, `F0` break, `E0` extended prefixes) into key-press events, buffers them in a small FIFO, and grants the FIFO head to exactly one consumer, selected by the game-in-progress flag. Replaces per-consumer scancode handling, so no consumer sees break codes or double-counts a byte.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ps_data` in 8: scancode byte from the PS/2 receiver; valid while `ready`=1.
- `ready` in 1: level from the PS/2 receiver; each 0→1 transition marks one new byte.
- `is_start` in 1: 1 = game running, so the head goes to the game; 0 = head goes to the menu.
- `menu_ack` in 1: menu pops the head; ignored unless `menu_valid`.
- `game_ack` in 1: game pops the head; ignored unless `game_valid`.
- `menu_valid` out 1: head available to the menu.
- `game_valid` out 1: head available to the game.
- `key_code` out 8: head scancode (make code, prefix stripped).
- `key_ext` out 1: head came from an `E0`-prefixed make.
- `overflow` out 1: sticky; a press was dropped because the FIFO was full.
- `held` out 1: a non-extended key is currently held (make seen, break not yet seen).

## Operation
- **Byte strobe:** `ready_q` registers `ready`; a byte is taken when `ready & ~ready_q`. No other bytes are consumed.
- **Decoder FSM:**
  - IDLE: `E0`→EXT; `F0`→BRK; any other byte is a make, pushed as {ext=0, code}, stay in IDLE.
  - EXT: `F0`→EXT_BRK; other byte is a make, pushed as {1, code}, →IDLE.
  - BRK: byte is a break; nothing pushed; if it equals `last_make`, clear `held`; →IDLE.
  - EXT_BRK: byte discarded; →IDLE.
  - A second `E0`/`F0` seen in BRK or EXT_BRK is treated as the data byte.
- **Make push:** sets `last_make`=code and `held`=1 (non-extended only).
- **Routing:**
  - `game_valid` = ~empty & `is_start`.
  - `menu_valid` = ~empty & ~`is_start`.
  - Never both high.
  - `key_code`/`key_ext` show the head whenever non-empty; 0 when empty.
- **Pop:** occurs when the routed consumer's ack is high at posedge; the other ack is ignored.
- **Flush:** `is_start_q` registers `is_start`. A cycle with `is_start != is_start_q` empties the FIFO, so stale menu keys never reach the game and vice versa. A push requested in a flush cycle is dropped; `overflow` is unaffected.
- **Full/empty:**
  - Push + pop in the same cycle is allowed at any occupancy, including full; count is unchanged.
  - Push when full without pop: entry dropped, `overflow`=1.
  - Pop when empty cannot occur (valid is low).
- **Reset values:**
  - State IDLE.
  - FIFO empty, both valids 0.
  - `key_code` 0, `key_ext` 0.
  - `overflow` 0, `held` 0, `last_make` 0.
  - `ready_q` 0, `is_start_q` 0.
- Reset asserted mid-sequence (after `F0`/`E0`) abandons the sequence.

## Timing
- Push is registered at the posedge ending the strobe cycle. Valid rises one cycle after the strobe cycle, so latency = 1 clk.
- Ack at edge k: the next entry, if any, is valid after edge k. Back-to-back pops are possible every cycle.
- `is_start` change seen at edge k: FIFO empty after edge k+1. Valids for the new owner stay low until the next push.
- All outputs are registered state or decode of registered state. There is no input→output combinational path except ack-independent muxing by `is_start`.

## Configuration
- `KBD_TYPEMATIC_FILTER_EN`
  - Defined: a make equal to `last_make` while `held`=1 is not pushed, which suppresses keyboard auto-repeat. One press gives one event.
  - Undefined: every make is pushed, including typematic repeats. `held`/`last_make` are still maintained.

## Structure
- Package `kbd_pkg`:
  - constants `SC_BREAK`=8'hF0, `SC_EXT`=8'hE0, `SC_ENTER`=8'h5A, `SC_BKSP`=8'h66;
  - enum `kbd_dec_state_t` {IDLE, EXT, BRK, EXT_BRK};
  - struct `kbd_evt_t` {ext, code[7:0]}.
- One sub-module, `kbd_evt_fifo`: synchronous FIFO of `kbd_evt_t`, `DEPTH` entries, pointer+count, with flush input. Decoder, strobe, and routing live in the top.

## Test plan
- Bytes `1C`, `F0`, `1C` with `is_start`=0 → one event: `menu_valid`=1, `key_code`=1C, `key_ext`=0, `held` 1→0; `game_valid` stays 0.
- `E0`, `75`, `E0`, `F0`, `75` with `is_start`=1 → one event: `game_valid`=1, `key_code`=75, `key_ext`=1.
- `1C` ×3 with no break:
  - with `KBD_TYPEMATIC_FILTER_EN` → exactly 1 event;
  - without it → 3 events.
- 5 distinct makes with no acks, `DEPTH`=4 → 4 events held, `overflow`=1. First pop returns the first code; the 5th code is never delivered.
- 2 queued events, toggle `is_start` 0→1 → both valids low two edges later and FIFO empty. A subsequent `16` → `game_valid`, code 16.
- Full FIFO, new make and `menu_ack` in the same cycle → count stays 4, new code queued last, `overflow` stays 0. Reset asserted mid-`F0` → all outputs at reset values; next byte `29` → event 29.
